// File: rtl/ldm_stm_mem_addr_generator.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_mem_addr_generator
// Purpose  : Memory-side address generator for ARM LDM/STM block transfers.
//            Runs in lock-step with the register address sequencer. It
//            produces one word address per enabled transfer cycle and a
//            base-register writeback value for the IA/IB/DA/DB modes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_in            - system clock; all state changes on the rising edge
//   reset_in          - synchronous, active-high reset
//   ldm_stm_start_in  - one-cycle start strobe
//   reg_list_in       - register list; sampled only in the start cycle
//   base_addr_in      - base register value; sampled in the start cycle
//   p_bit_in          - pre-index (1) or post-index (0)
//   u_bit_in          - up (1) or down (0)
//   w_bit_in          - base writeback request
//   ldm_stm_en_in     - per-transfer enable from the register sequencer
//   mem_addr_out      - word address of the current transfer
//   mem_req_out       - a transfer is valid this cycle
//   base_wb_data_out  - new base value; held until the next start
//   base_wb_en_out    - one-cycle base writeback strobe
//   busy_out          - a block transfer is in progress
//   done_out          - one-cycle completion pulse
//   seq_err_out       - one-cycle pulse when the enable stream and the
//                       transfer count disagree
//   align_err_out     - (only with LDM_STM_MEM_ALIGN_CHECK_EN) pulses in the
//                       start cycle when the base is not word aligned
// Configuration macro: LDM_STM_MEM_ALIGN_CHECK_EN
// ============================================================================
module ldm_stm_mem_addr_generator #(
   parameter int ADDR_W = 32,
   parameter int LIST_W = 16
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              ldm_stm_start_in,
   input  logic [LIST_W-1:0] reg_list_in,
   input  logic [ADDR_W-1:0] base_addr_in,
   input  logic              p_bit_in,
   input  logic              u_bit_in,
   input  logic              w_bit_in,
   input  logic              ldm_stm_en_in,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic              mem_req_out,
   output logic [ADDR_W-1:0] base_wb_data_out,
   output logic              base_wb_en_out,
   output logic              busy_out,
   output logic              done_out,
`ifdef LDM_STM_MEM_ALIGN_CHECK_EN
   output logic              seq_err_out,
   output logic              align_err_out
`else
   output logic              seq_err_out
`endif
);

   localparam int CNT_W = $clog2(LIST_W + 1);
   localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_XFER   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  remaining_q;
   logic [ADDR_W-1:0] wb_q;
   logic              wb_req_q;

   logic [ADDR_W-1:0] base_d;
   logic [CNT_W-1:0]  count_d;
   logic [ADDR_W-1:0] span_d;
   logic [ADDR_W-1:0] start_addr_d;
   logic [ADDR_W-1:0] wb_d;
   logic              start_acc_d;

   // Base used for all arithmetic; the alignment option drops the byte offset.
`ifdef LDM_STM_MEM_ALIGN_CHECK_EN
   assign base_d = {base_addr_in[ADDR_W-1:2], 2'b00};
`else
   assign base_d = base_addr_in;
`endif

   // Number of registers in the list.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < LIST_W; i++) begin
         count_d = count_d + CNT_W'(reg_list_in[i]);
      end
   end

   // Byte span of the whole block: 4*N.
   assign span_d = ADDR_W'({count_d, 2'b00});

   // Addresses always ascend, so the descending modes start at the bottom of
   // the block and walk up toward the base.
   always_comb begin
      start_addr_d = base_d;
      case ({p_bit_in, u_bit_in})
         2'b01:   start_addr_d = base_d;                              // IA
         2'b11:   start_addr_d = base_d + WORD_BYTES;                 // IB
         2'b00:   start_addr_d = base_d - span_d + WORD_BYTES;        // DA
         default: start_addr_d = base_d - span_d;                     // DB
      endcase
   end

   assign wb_d = u_bit_in ? (base_d + span_d) : (base_d - span_d);

   // A start is only honoured from IDLE; starts during XFER/FINISH are dropped.
   assign start_acc_d = (state_q == ST_IDLE) && ldm_stm_start_in;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         wb_q        <= '0;
         wb_req_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ldm_stm_start_in) begin
                  wb_q <= wb_d;
                  if (count_d == '0) begin
                     // Empty list: complete without transfers or writeback.
                     addr_q      <= '0;
                     remaining_q <= '0;
                     wb_req_q    <= 1'b0;
                     state_q     <= ST_FINISH;
                  end else begin
                     // The first transfer is issued in the start cycle itself.
                     addr_q      <= start_addr_d + WORD_BYTES;
                     remaining_q <= count_d - CNT_ONE;
                     wb_req_q    <= w_bit_in;
                     state_q     <= (count_d == CNT_ONE) ? ST_FINISH : ST_XFER;
                  end
               end
            end
            ST_XFER: begin
               if (ldm_stm_en_in) begin
                  addr_q      <= addr_q + WORD_BYTES;
                  remaining_q <= remaining_q - CNT_ONE;
                  if (remaining_q == CNT_ONE) begin
                     state_q <= ST_FINISH;
                  end
               end else begin
                  // Sequencer stalled early: abandon the block.
                  state_q <= ST_IDLE;
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the registered state; the start cycle needs the
   // combinational start address so the first transfer is not delayed.
   always_comb begin
      mem_addr_out   = '0;
      mem_req_out    = 1'b0;
      busy_out       = 1'b0;
      done_out       = 1'b0;
      base_wb_en_out = 1'b0;
      seq_err_out    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_acc_d) begin
               busy_out = 1'b1;
               if (count_d != '0) begin
                  mem_addr_out = start_addr_d;
                  mem_req_out  = ldm_stm_en_in;
               end
            end
         end
         ST_XFER: begin
            busy_out     = 1'b1;
            mem_addr_out = addr_q;
            mem_req_out  = ldm_stm_en_in;
            seq_err_out  = ~ldm_stm_en_in;
         end
         ST_FINISH: begin
            busy_out       = 1'b1;
            done_out       = 1'b1;
            base_wb_en_out = wb_req_q;
            // An enable here is one transfer too many; it is not issued.
            seq_err_out    = ldm_stm_en_in;
         end
         default: begin
            busy_out = 1'b0;
         end
      endcase
   end

   assign base_wb_data_out = wb_q;

`ifdef LDM_STM_MEM_ALIGN_CHECK_EN
   assign align_err_out = start_acc_d && (base_addr_in[1:0] != 2'b00);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_mem_addr_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldm_stm_mem_addr_generator
// Purpose  : Scoreboard bench for ldm_stm_mem_addr_generator. Stimulus pushes
//            hand-computed expected events; a monitor pops and compares them
//            whenever the DUT presents a request, completion or error.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_mem_addr_generator;

   localparam int EV_REQ   = 0;
   localparam int EV_DONE  = 1;
   localparam int EV_ERR   = 2;
   localparam int EV_ALIGN = 3;

   typedef struct {
      int          kind;
      logic [31:0] val;
      logic        wb;
   } ev_t;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        ldm_stm_start_in;
   logic [15:0] reg_list_in;
   logic [31:0] base_addr_in;
   logic        p_bit_in;
   logic        u_bit_in;
   logic        w_bit_in;
   logic        ldm_stm_en_in;
   logic [31:0] mem_addr_out;
   logic        mem_req_out;
   logic [31:0] base_wb_data_out;
   logic        base_wb_en_out;
   logic        busy_out;
   logic        done_out;
   logic        seq_err_out;
`ifdef LDM_STM_MEM_ALIGN_CHECK_EN
   logic        align_err_out;
`endif

   ev_t exp_q[$];
   int  total = 0;
   int  bad   = 0;
   bit  mon_on = 1'b0;

   always #5 clk_in = ~clk_in;

   ldm_stm_mem_addr_generator #(.ADDR_W(32), .LIST_W(16)) dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .ldm_stm_start_in (ldm_stm_start_in),
      .reg_list_in      (reg_list_in),
      .base_addr_in     (base_addr_in),
      .p_bit_in         (p_bit_in),
      .u_bit_in         (u_bit_in),
      .w_bit_in         (w_bit_in),
      .ldm_stm_en_in    (ldm_stm_en_in),
      .mem_addr_out     (mem_addr_out),
      .mem_req_out      (mem_req_out),
      .base_wb_data_out (base_wb_data_out),
      .base_wb_en_out   (base_wb_en_out),
      .busy_out         (busy_out),
      .done_out         (done_out),
`ifdef LDM_STM_MEM_ALIGN_CHECK_EN
      .seq_err_out      (seq_err_out),
      .align_err_out    (align_err_out)
`else
      .seq_err_out      (seq_err_out)
`endif
   );

   task automatic push_ev(input int kind, input logic [31:0] val, input logic wb);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.wb   = wb;
      exp_q.push_back(e);
   endtask

   task automatic check_ev(input int kind, input logic [31:0] val, input logic wb);
      ev_t e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL unexpected_event: got kind=%0d val=%h wb=%b, none expected",
                  kind, val, wb);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.wb != wb) begin
            bad++;
            $display("FAIL event: got kind=%0d val=%h wb=%b, required kind=%0d val=%h wb=%b",
                     kind, val, wb, e.kind, e.val, e.wb);
         end
      end
   endtask

   // Monitor: samples on the falling edge, away from input changes.
   always @(negedge clk_in) begin
      if (mon_on) begin
`ifdef LDM_STM_MEM_ALIGN_CHECK_EN
         if (align_err_out) check_ev(EV_ALIGN, 32'h0, 1'b0);
`endif
         if (mem_req_out) check_ev(EV_REQ, mem_addr_out, 1'b0);
         if (done_out)    check_ev(EV_DONE, base_wb_data_out, base_wb_en_out);
         if (seq_err_out) check_ev(EV_ERR, 32'h0, 1'b0);
      end
   end

   task automatic check_zero(input string name);
      logic [68:0] obs;
      @(negedge clk_in);
      obs = {mem_addr_out, mem_req_out, base_wb_data_out, base_wb_en_out,
             busy_out, done_out, seq_err_out};
      total++;
      if (obs != '0) begin
         bad++;
         $display("FAIL %s: outputs=%h, required all zero", name, obs);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_in);
         #1;
         ldm_stm_start_in = 1'b0;
         ldm_stm_en_in    = 1'b0;
      end
   endtask

   // Start a block and hold the enable high for en_cycles cycles, counting
   // the start cycle as the first one.
   task automatic run_block(input logic p, input logic u, input logic w,
                            input logic [31:0] base, input logic [15:0] list,
                            input int en_cycles);
      @(posedge clk_in);
      #1;
      ldm_stm_start_in = 1'b1;
      reg_list_in      = list;
      base_addr_in     = base;
      p_bit_in         = p;
      u_bit_in         = u;
      w_bit_in         = w;
      ldm_stm_en_in    = (en_cycles > 0);
      for (int k = 1; k < en_cycles; k++) begin
         @(posedge clk_in);
         #1;
         ldm_stm_start_in = 1'b0;
         reg_list_in      = 16'h0;
         base_addr_in     = 32'h0;
         ldm_stm_en_in    = 1'b1;
      end
      @(posedge clk_in);
      #1;
      ldm_stm_start_in = 1'b0;
      reg_list_in      = 16'h0;
      base_addr_in     = 32'h0;
      ldm_stm_en_in    = 1'b0;
      idle_cycles(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_in         = 1'b1;
      ldm_stm_start_in = 1'b0;
      reg_list_in      = 16'h0;
      base_addr_in     = 32'h0;
      p_bit_in         = 1'b0;
      u_bit_in         = 1'b0;
      w_bit_in         = 1'b0;
      ldm_stm_en_in    = 1'b0;
      repeat (3) @(posedge clk_in);
      check_zero("reset_state");
      @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      mon_on   = 1'b1;
      check_zero("idle_after_reset");

      // IA, base 0x1000, four registers, writeback.
      push_ev(EV_REQ, 32'h1000, 1'b0);
      push_ev(EV_REQ, 32'h1004, 1'b0);
      push_ev(EV_REQ, 32'h1008, 1'b0);
      push_ev(EV_REQ, 32'h100C, 1'b0);
      push_ev(EV_DONE, 32'h1010, 1'b1);
      run_block(1'b0, 1'b1, 1'b1, 32'h1000, 16'h000F, 4);

      // Idle: address bus parked at zero, not busy.
      @(negedge clk_in);
      total++;
      if (mem_addr_out != 32'h0 || busy_out != 1'b0) begin
         bad++;
         $display("FAIL idle_outputs: addr=%h busy=%b, required addr=0 busy=0",
                  mem_addr_out, busy_out);
      end

      // DB, base 0x2000, two registers.
      push_ev(EV_REQ, 32'h1FF8, 1'b0);
      push_ev(EV_REQ, 32'h1FFC, 1'b0);
      push_ev(EV_DONE, 32'h1FF8, 1'b1);
      run_block(1'b1, 1'b0, 1'b1, 32'h2000, 16'h8001, 2);

      // DA, same inputs.
      push_ev(EV_REQ, 32'h1FFC, 1'b0);
      push_ev(EV_REQ, 32'h2000, 1'b0);
      push_ev(EV_DONE, 32'h1FF8, 1'b1);
      run_block(1'b0, 1'b0, 1'b1, 32'h2000, 16'h8001, 2);

      // IB with wrap-around, no writeback (WB value 0xFFFFFFF8+12 = 0x4).
      push_ev(EV_REQ, 32'hFFFFFFFC, 1'b0);
      push_ev(EV_REQ, 32'h00000000, 1'b0);
      push_ev(EV_REQ, 32'h00000004, 1'b0);
      push_ev(EV_DONE, 32'h00000004, 1'b0);
      run_block(1'b1, 1'b1, 1'b0, 32'hFFFFFFF8, 16'h0007, 3);

      // Empty list: completion only, writeback suppressed even with W=1.
      push_ev(EV_DONE, 32'h3000, 1'b0);
      run_block(1'b0, 1'b1, 1'b1, 32'h3000, 16'h0000, 0);

      // Full list, IA from 0.
      for (int k = 0; k < 16; k++) push_ev(EV_REQ, 32'(k * 4), 1'b0);
      push_ev(EV_DONE, 32'h40, 1'b1);
      run_block(1'b0, 1'b1, 1'b1, 32'h0, 16'hFFFF, 16);

      // Enable dropped after 2 of 4 transfers: error, no completion.
      push_ev(EV_REQ, 32'h500, 1'b0);
      push_ev(EV_REQ, 32'h504, 1'b0);
      push_ev(EV_ERR, 32'h0, 1'b0);
      run_block(1'b0, 1'b1, 1'b1, 32'h500, 16'h00F0, 2);

      // Reset mid-transfer: the third transfer is visible in the reset cycle,
      // then everything is zero and no completion follows.
      push_ev(EV_REQ, 32'h600, 1'b0);
      push_ev(EV_REQ, 32'h604, 1'b0);
      push_ev(EV_REQ, 32'h608, 1'b0);
      @(posedge clk_in);
      #1;
      ldm_stm_start_in = 1'b1;
      reg_list_in      = 16'h000F;
      base_addr_in     = 32'h600;
      p_bit_in         = 1'b0;
      u_bit_in         = 1'b1;
      w_bit_in         = 1'b1;
      ldm_stm_en_in    = 1'b1;
      @(posedge clk_in);
      #1;
      ldm_stm_start_in = 1'b0;
      @(posedge clk_in);
      #1;
      reset_in = 1'b1;
      @(posedge clk_in);
      #1;
      ldm_stm_en_in = 1'b0;
      check_zero("reset_mid_xfer");
      @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      idle_cycles(3);

      // Second start while busy is ignored.
      push_ev(EV_REQ, 32'h700, 1'b0);
      push_ev(EV_REQ, 32'h704, 1'b0);
      push_ev(EV_DONE, 32'h708, 1'b1);
      @(posedge clk_in);
      #1;
      ldm_stm_start_in = 1'b1;
      reg_list_in      = 16'h0003;
      base_addr_in     = 32'h700;
      p_bit_in         = 1'b0;
      u_bit_in         = 1'b1;
      w_bit_in         = 1'b1;
      ldm_stm_en_in    = 1'b1;
      @(posedge clk_in);
      #1;
      reg_list_in  = 16'h00FF;
      base_addr_in = 32'h900;
      @(posedge clk_in);
      #1;
      ldm_stm_en_in = 1'b0;
      idle_cycles(3);

`ifdef LDM_STM_MEM_ALIGN_CHECK_EN
      // Misaligned base: flagged, then transferred from the aligned base.
      push_ev(EV_ALIGN, 32'h0, 1'b0);
      push_ev(EV_REQ, 32'h1000, 1'b0);
      push_ev(EV_REQ, 32'h1004, 1'b0);
      push_ev(EV_DONE, 32'h1008, 1'b1);
      run_block(1'b0, 1'b1, 1'b1, 32'h1003, 16'h0003, 2);
`endif

      idle_cycles(4);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d events still pending, required 0",
                  exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ldm_stm_mem_addr_generator.md
Name: ldm_stm_mem_addr_generator

Overview:
- Memory-side companion to the LDM/STM register address sequencer.
- Consumes the same start strobe and 16-bit register list, plus the per-transfer enable stream that sequencer emits.
- Produces the word address for each transfer under the four ARM block-transfer modes (IA/IB/DA/DB), and the base-register writeback value.
- Sits between the decode/control path and the data memory interface, in lock-step with the register address stream.

Parameters:
ADDR_W, 32, width of base and memory addresses
LIST_W, 16, width of register list; max transfer count

Ports:
clk_in  input  1  system clock, all state updates on rising edge
reset_in  input  1  synchronous, active-high reset
ldm_stm_start_in  input  1  one-cycle start strobe, same cycle as the register sequencer's start
reg_list_in  input  LIST_W  register list; sampled only in the start cycle
base_addr_in  input  ADDR_W  base register value; sampled in the start cycle
p_bit_in  input  1  pre-index (1) / post-index (0); sampled at start
u_bit_in  input  1  up (1) / down (0); sampled at start
w_bit_in  input  1  base writeback request; sampled at start
ldm_stm_en_in  input  1  per-transfer enable from register sequencer; one transfer per high cycle
mem_addr_out  output  ADDR_W  word address for the current transfer
mem_req_out  output  1  transfer valid this cycle
base_wb_data_out  output  ADDR_W  new base value
base_wb_en_out  output  1  one-cycle base writeback strobe
busy_out  output  1  block transfer in progress
done_out  output  1  one-cycle completion pulse
seq_err_out  output  1  one-cycle pulse on enable/count mismatch

Behaviour:
- Reset: state IDLE; all outputs 0; internal address, count and writeback registers 0. Reset mid-transfer aborts the transfer with no done_out and no writeback.
- N = popcount(reg_list_in), range 0..16, held in 5 bits.
- Start address S by mode:
  - IA (P=0,U=1): base
  - IB (P=1,U=1): base+4
  - DA (P=0,U=0): base-4N+4
  - DB (P=1,U=0): base-4N
- Writeback value WB: U ? base+4N : base-4N. All address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Addresses always ascend by 4 per transfer, matching the low-to-high register order of the register sequencer.
- States: IDLE, XFER, FINISH.
- IDLE:
  - On start with N>0: mem_addr_out=S combinationally in the start cycle; mem_req_out=ldm_stm_en_in.
  - Latch addr_reg=S+4, remaining=N-1, WB and W. Go to XFER, or to FINISH if N=1.
  - On start with N=0: go to FINISH with no transfers and no writeback.
  - mem_addr_out holds 0 while idle.
- XFER:
  - mem_addr_out=addr_reg; mem_req_out=ldm_stm_en_in; busy_out=1.
  - Each cycle with ldm_stm_en_in=1: addr_reg+=4, remaining-=1. When remaining reaches 0, go to FINISH.
  - ldm_stm_en_in=0 while remaining>0: pulse seq_err_out and return to IDLE (no done_out, no writeback).
- FINISH (one cycle):
  - done_out=1.
  - base_wb_en_out=W (0 if N=0); base_wb_data_out=WB, held until the next start.
  - ldm_stm_en_in=1 in this cycle: pulse seq_err_out (extra transfer); the transfer is not issued.
  - Return to IDLE.
- busy_out: 1 in the start cycle and in XFER/FINISH.
- Start while busy_out=1 is ignored.
- Start in the FINISH cycle is ignored; the minimum start-to-start spacing is N+1 cycles.

Optional Feature:
- Macro LDM_STM_MEM_ALIGN_CHECK_EN.
- Defined:
  - base_addr_in[1:0] is forced to 00 before all arithmetic.
  - Added output align_err_out (1 bit, reset 0) pulses in the start cycle when base_addr_in[1:0]!=00; the transfer still proceeds using the aligned base.
- Undefined:
  - Base is used unmodified.
  - align_err_out port is absent.

Test Plan:
- IA, base=0x1000, list=0x000F, W=1, enable high 4 cycles -> addresses 0x1000,0x1004,0x1008,0x100C; done_out one cycle later; base_wb_data_out=0x1010 with base_wb_en_out=1.
- DB, base=0x2000, list=0x8001, W=1 -> addresses 0x1FF8,0x1FFC; writeback 0x1FF8. DA same inputs -> 0x1FFC,0x2000; writeback 0x1FF8.
- IB, base=0xFFFFFFF8, list=0x0007, W=0 -> addresses 0xFFFFFFFC,0x00000000,0x00000004; no base_wb_en_out; done_out asserted.
- list=0x0000 -> no mem_req_out; done_out next cycle; base_wb_en_out=0. list=0xFFFF, IA base 0 -> 16 requests ending at 0x3C; writeback 0x40.
- Enable dropped after 2 of 4 transfers -> seq_err_out pulse, return to IDLE, no done_out. Reset asserted mid-XFER -> all outputs 0 the next cycle. Second start during busy -> ignored.
- With LDM_STM_MEM_ALIGN_CHECK_EN, IA base=0x1003, list=0x0003 -> align_err_out pulse in the start cycle; addresses 0x1000,0x1004.
